// File: rtl/leiwand_rv32_wb_ram_pkg.sv
// Shared constants, FSM encoding and sizing helper for the leiwand RV32 Wishbone RAM.
// Imported by the RAM top and its storage array.
package leiwand_rv32_wb_ram_pkg;

    localparam int MEM_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Index of the highest set bit of v (0 for v <= 1); a counter holding v needs this + 1 bits.
    function automatic int high_bit_to_fit(input int unsigned v);
        int hb;
        hb = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                hb = i;
            end
        end
        return hb;
    endfunction

endpackage

// File: rtl/leiwand_rv32_wb_ram_array.sv
// Single-port synchronous word array with write enable; no reset on contents.
// Latency: read data registered, valid the cycle after the address edge.
// Backpressure: none, one access per clock.
module leiwand_rv32_wb_ram_array
    import leiwand_rv32_wb_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int          AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [MEM_WIDTH-1:0] i_data,
    output logic [MEM_WIDTH-1:0] o_data
);

    logic [MEM_WIDTH-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_data;
        end
        o_data <= mem_q[i_addr];
    end

endmodule

// File: rtl/leiwand_rv32_wb_ram.sv
// Wishbone pipelined-style RAM slave for the leiwand RV32 core; optional o_err via LEIWAND_RV32_RAM_ERR_EN.
// Latency: ack in cycle N+1+WAIT_STATES after the accept cycle N; back-to-back accepts from ACK.
// Backpressure: o_stall high only while counting wait states; one outstanding transfer.
module leiwand_rv32_wb_ram
    import leiwand_rv32_wb_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cyc,
    input  logic                 i_stb,
    input  logic                 i_we,
    input  logic [MEM_WIDTH-1:0] i_addr,
    input  logic [MEM_WIDTH-1:0] i_data,
    output logic [MEM_WIDTH-1:0] o_data,
    output logic                 o_ack,
`ifdef LEIWAND_RV32_RAM_ERR_EN
    output logic                 o_err,
`endif
    output logic                 o_stall
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam int          CNT_W    = high_bit_to_fit(WAIT_STATES) + 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 in_rng_q, in_rng_d;

    logic                 accept;
    logic                 in_rng_i;
    logic                 ack_cyc;
    logic                 arr_we;
    logic [MEM_WIDTH-1:0] arr_addr;
    logic [MEM_WIDTH-1:0] arr_wdata;
    logic [MEM_WIDTH-1:0] arr_rdata;
    logic [MEM_WIDTH-1:0] arr_off;
    logic [AW-1:0]        arr_idx;
    logic                 unused_off;

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    function automatic logic in_range(input logic [MEM_WIDTH-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
    endfunction

    assign in_rng_i = in_range(i_addr);
    assign o_stall  = (state_q == ST_WAIT);
    assign accept   = i_cyc && i_stb && !o_stall &&
                      ((state_q == ST_IDLE) || (state_q == ST_ACK));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        in_rng_d = in_rng_q;
        arr_we   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACK: begin
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d   = i_addr;
                    wdata_d  = i_data;
                    we_d     = i_we;
                    in_rng_d = in_rng_i;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                        arr_we  = i_we && in_rng_i;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (!i_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                    arr_we  = we_q && in_rng_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A write whose commit edge coincides with reset is lost.
        if (!i_rst_n) begin
            arr_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            in_rng_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            in_rng_q <= in_rng_d;
        end
    end

    // With zero wait states the array sees the live request on the accept edge.
    assign arr_addr   = (state_q == ST_WAIT) ? addr_q  : i_addr;
    assign arr_wdata  = (state_q == ST_WAIT) ? wdata_q : i_data;
    assign arr_off    = arr_addr - BASE_ADDR;
    assign arr_idx    = arr_off[AW+1:2];
    assign unused_off = ^arr_off;

    leiwand_rv32_wb_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk  (i_clk),
        .i_we   (arr_we),
        .i_addr (arr_idx),
        .i_data (arr_wdata),
        .o_data (arr_rdata)
    );

    assign ack_cyc = (state_q == ST_ACK) && i_cyc;
    assign o_data  = (ack_cyc && !we_q && in_rng_q) ? arr_rdata : '0;

`ifdef LEIWAND_RV32_RAM_ERR_EN
    assign o_ack = ack_cyc && in_rng_q;
    assign o_err = ack_cyc && !in_rng_q;
`else
    assign o_ack = ack_cyc;
`endif

endmodule

// File: tb/tb_leiwand_rv32_wb_ram.sv
// Bench for leiwand_rv32_wb_ram: three instances (0, 1 and 3 wait states) against a word-array
// reference model, with a scoreboard monitor checking every output cycle.
module tb_leiwand_rv32_wb_ram;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 16;
    localparam int          NI    = 3;
`ifdef LEIWAND_RV32_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          inst;
        int          due;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b_cyc   [NI];
    logic        b_stb   [NI];
    logic        b_we    [NI];
    logic [31:0] b_addr  [NI];
    logic [31:0] b_wdat  [NI];
    logic [31:0] b_rdata [NI];
    logic        b_ack   [NI];
    logic        b_err   [NI];
    logic        b_stall [NI];

    logic [31:0] ref_mem [NI][DEPTH];
    exp_t        sb[$];
    int          cyc_cnt = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned WSV = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        leiwand_rv32_wb_ram #(
            .BASE_ADDR   (BASE),
            .DEPTH_WORDS (DEPTH),
            .WAIT_STATES (WSV)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_cyc   (b_cyc[g]),
            .i_stb   (b_stb[g]),
            .i_we    (b_we[g]),
            .i_addr  (b_addr[g]),
            .i_data  (b_wdat[g]),
            .o_data  (b_rdata[g]),
            .o_ack   (b_ack[g]),
`ifdef LEIWAND_RV32_RAM_ERR_EN
            .o_err   (b_err[g]),
`endif
            .o_stall (b_stall[g])
        );
    end

`ifndef LEIWAND_RV32_RAM_ERR_EN
    initial for (int k = 0; k < NI; k++) b_err[k] = 1'b0;
`endif

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned x, lo;
        x  = a;
        lo = BASE;
        return (x >= lo) && (x < lo + 4 * DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2) & (DEPTH - 1);
    endfunction

    function automatic void chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @cycle %0d: got %h expected %h", nm, k, cyc_cnt, act, exp);
        end
    endfunction

    function automatic exp_t model(input int k, input bit we, input logic [31:0] a, input logic [31:0] d, input int due);
        exp_t e;
        e.inst = k;
        e.due  = due;
        e.err  = ERR_EN && !in_rng(a);
        e.data = (!we && in_rng(a)) ? ref_mem[k][idx_of(a)] : 32'h0;
        if (we && in_rng(a)) ref_mem[k][idx_of(a)] = d;
        return e;
    endfunction

    // Monitor: each cycle, either the oldest pending response of an instance is due, or it must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NI; k++) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].inst == k) begin
                        idx = i;
                        break;
                    end
                end
                if (idx >= 0 && sb[idx].due == cyc_cnt) begin
                    chk("ack", k, 32'(b_ack[k]), 32'(!sb[idx].err));
                    chk("err", k, 32'(b_err[k]), 32'(sb[idx].err));
                    chk("rdata", k, b_rdata[k], sb[idx].data);
                    sb.delete(idx);
                end else begin
                    chk("idle_ack", k, 32'(b_ack[k]), 32'h0);
                    chk("idle_err", k, 32'(b_err[k]), 32'h0);
                    chk("idle_data", k, b_rdata[k], 32'h0);
                end
            end
        end
    end

    // All tasks start and end #1 after a rising edge.
    task automatic xfer(input int k, input bit we, input logic [31:0] a, input logic [31:0] d);
        sb.push_back(model(k, we, a, d, cyc_cnt + 1 + ws_of(k)));
        b_cyc[k] = 1'b1; b_stb[k] = 1'b1; b_we[k] = we; b_addr[k] = a; b_wdat[k] = d;
        @(posedge clk); #1;
        b_stb[k] = 1'b0;
        for (int i = 0; i < ws_of(k); i++) begin
            chk("stall_wait", k, 32'(b_stall[k]), 32'h1);
            @(posedge clk); #1;
        end
        chk("stall_ack", k, 32'(b_stall[k]), 32'h0);
        @(posedge clk); #1;
        b_cyc[k] = 1'b0;
    endtask

    task automatic b2b_rd(input int k, input logic [31:0] a0, input logic [31:0] a1);
        sb.push_back(model(k, 1'b0, a0, 32'h0, cyc_cnt + 1));
        b_cyc[k] = 1'b1; b_stb[k] = 1'b1; b_we[k] = 1'b0; b_addr[k] = a0;
        @(posedge clk); #1;
        chk("b2b_stall0", k, 32'(b_stall[k]), 32'h0);
        sb.push_back(model(k, 1'b0, a1, 32'h0, cyc_cnt + 1));
        b_addr[k] = a1;
        @(posedge clk); #1;
        b_stb[k] = 1'b0;
        chk("b2b_stall1", k, 32'(b_stall[k]), 32'h0);
        @(posedge clk); #1;
        b_cyc[k] = 1'b0;
    endtask

    task automatic abort_wr(input int k, input logic [31:0] a, input logic [31:0] d);
        b_cyc[k] = 1'b1; b_stb[k] = 1'b1; b_we[k] = 1'b1; b_addr[k] = a; b_wdat[k] = d;
        @(posedge clk); #1;
        b_stb[k] = 1'b0;
        chk("abort_stall1", k, 32'(b_stall[k]), 32'h1);
        @(posedge clk); #1;
        b_cyc[k] = 1'b0;
        chk("abort_stall2", k, 32'(b_stall[k]), 32'h1);
        @(posedge clk); #1;
        chk("abort_idle", k, 32'(b_stall[k]), 32'h0);
        @(posedge clk); #1;
    endtask

    // Reset asserted in cycle N+at of a transfer issued in cycle N; cyc held high through reset.
    task automatic rst_mid(input int k, input bit we, input logic [31:0] a, input logic [31:0] d, input int at);
        b_cyc[k] = 1'b1; b_stb[k] = 1'b1; b_we[k] = we; b_addr[k] = a; b_wdat[k] = d;
        @(posedge clk); #1;
        b_stb[k] = 1'b0;
        for (int i = 1; i < at; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_stall", k, 32'(b_stall[k]), 32'h0);
        chk("rst_ack", k, 32'(b_ack[k]), 32'h0);
        chk("rst_data", k, b_rdata[k], 32'h0);
        rst_n = 1'b1;
        b_cyc[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int r, k;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            b_cyc[i] = 1'b0; b_stb[i] = 1'b0; b_we[i] = 1'b0; b_addr[i] = '0; b_wdat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("reset_ack", i, 32'(b_ack[i]), 32'h0);
            chk("reset_stall", i, 32'(b_stall[i]), 32'h0);
            chk("reset_data", i, b_rdata[i], 32'h0);
            chk("reset_err", i, 32'(b_err[i]), 32'h0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NI; i++)
            for (int w = 0; w < DEPTH; w++)
                xfer(i, 1'b1, BASE + 32'(4 * w), $urandom);

        xfer(1, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h1000_0008, 32'h0);
        b2b_rd(0, 32'h1000_0000, 32'h1000_0004);

        for (int i = 0; i < NI; i++) begin
            xfer(i, 1'b1, 32'h0FFF_FFFC, $urandom);
            xfer(i, 1'b1, BASE + 32'(4 * DEPTH), $urandom);
            xfer(i, 1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0);
            xfer(i, 1'b0, 32'h0FFF_FFFC, 32'h0);
        end

        abort_wr(2, BASE + 32'd24, 32'hA5A5_0001);
        xfer(2, 1'b0, BASE + 32'd24, 32'h0);

        rst_mid(1, 1'b0, 32'h1000_0008, 32'h0, 1);
        xfer(1, 1'b0, 32'h1000_0008, 32'h0);
        rst_mid(2, 1'b1, BASE + 32'd20, 32'h5A5A_0002, 3);
        xfer(2, 1'b0, BASE + 32'd20, 32'h0);

        for (int it = 0; it < 120; it++) begin
            k = $urandom_range(0, NI - 1);
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0 && k == 0)
                b2b_rd(0, a, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)));
            else
                xfer(k, 1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 0, 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/leiwand_rv32_wb_ram.md
LEIWAND_RV32_WB_RAM -- requirements
Module: leiwand_rv32_wb_ram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10000000: byte address of word 0, equal to the core's PC start value.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; must be a power of two.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15: extra cycles between request accept and ack.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port i_cyc, input, 1 bit: Wishbone cycle.
REQ-007 SHALL have port i_stb, input, 1 bit: Wishbone strobe.
REQ-008 SHALL have port i_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port i_addr, input, `MEM_WIDTH bits: byte address.
REQ-010 SHALL have port i_data, input, `MEM_WIDTH bits: write data.
REQ-011 SHALL have port o_data, output, `MEM_WIDTH bits: read data.
REQ-012 SHALL have port o_ack, output, 1 bit: transfer complete.
REQ-013 SHALL have port o_stall, output, 1 bit: slave busy; a request is not accepted while this is high.
REQ-014 SHALL have port o_err, output, 1 bit: out-of-range access; present only when LEIWAND_RV32_RAM_ERR_EN is defined.

Function
REQ-015 SHALL implement a state machine with states IDLE, WAIT and ACK; a request is accepted when i_cyc & i_stb & !o_stall is sampled at a rising edge in IDLE or ACK.
REQ-016 SHALL, on accept, latch i_addr, i_we and i_data, then go to WAIT loaded with WAIT_STATES, or go directly to ACK if WAIT_STATES==0.
REQ-017 SHALL decrement the WAIT counter once per cycle and enter ACK on the edge where the count is 1.
REQ-018 SHALL assert o_ack for exactly one cycle, cycle N+1+WAIT_STATES, where N is the accept cycle.
REQ-019 SHALL drive o_stall=1 only in WAIT, so o_stall=0 during the ack cycle; the core requires i_ack && !i_stall to complete.
REQ-020 SHALL, in a read ack cycle, drive o_data with mem[(addr-BASE_ADDR)>>2]; o_data SHALL be 0 in all other cycles and for writes.
REQ-021 SHALL commit a write to the array on the edge entering ACK; addr[1:0] SHALL be ignored, with no byte lanes.
REQ-022 SHALL treat an address as in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, with 32-bit unsigned compare and no wrap-around.
REQ-023 SHALL, when a request arrives in the ACK state, accept it back-to-back; otherwise ACK SHALL return to IDLE.
REQ-024 SHALL abort when i_cyc is low in WAIT: go to IDLE next edge, no ack, no write committed.
REQ-025 SHALL gate ack with i_cyc: o_ack = (state==ACK) & i_cyc.
REQ-026 SHALL, when i_cyc is low in ACK, suppress o_ack, but a write already committed SHALL stand.
REQ-027 SHALL allow at most one outstanding transfer.

Reset
REQ-028 SHALL, while i_rst_n=0 at an edge, force state=IDLE, counter=0 and latched request fields=0.
REQ-029 SHALL hold o_ack=0, o_stall=0, o_data=0 and o_err=0 from the first edge with i_rst_n=0 until the first edge after it is released.
REQ-030 SHALL leave array contents unchanged by reset.
REQ-031 SHALL, on reset mid-transfer, drop the transfer without ack; a write not yet committed SHALL be lost.

Configuration
REQ-032 SHALL, with LEIWAND_RV32_RAM_ERR_EN defined, pulse o_err instead of o_ack, with the same timing, for out-of-range accesses; writes are dropped and o_data=0.
REQ-033 SHALL, without LEIWAND_RV32_RAM_ERR_EN, omit the o_err port and ack out-of-range accesses normally: reads return 0, writes are dropped.

Structure
REQ-034 SHALL place `MEM_WIDTH and the IDLE/WAIT/ACK state encodings in the shared leiwand_rv32_constants.v include.
REQ-035 SHALL reuse `HIGH_BIT_TO_FIT from helper.v for the counter width.
REQ-036 SHALL implement the storage as sub-module leiwand_rv32_wb_ram_array: a single-port synchronous array of DEPTH_WORDS x 32 with write enable.

Verification
REQ-037 SHALL verify: WAIT_STATES=1, write 32'hDEADBEEF to 32'h10000008 with stb at cycle N -> o_stall=1 in N+1, o_ack=1 with o_stall=0 in N+2.
REQ-038 SHALL verify: read of 32'h10000008 after REQ-037 -> o_data=32'hDEADBEEF in the ack cycle, 0 in the next cycle.
REQ-039 SHALL verify: WAIT_STATES=0, back-to-back reads of 32'h10000000 and 32'h10000004 -> acks in N+1 and N+2, o_stall never high.
REQ-040 SHALL verify: write to 32'h0FFFFFFC -> with ERR_EN, o_err=1 and o_ack=0; without ERR_EN, o_ack=1; in both cases a read of the last valid word is unchanged.
REQ-041 SHALL verify: WAIT_STATES=3, i_cyc dropped in N+2 -> no ack, state IDLE at N+3, target word unchanged.
REQ-042 SHALL verify: i_rst_n=0 in N+1 during a read -> o_ack, o_stall and o_data all 0, and previously written data is intact afterward.
